// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display bank: segment patterns and blink sizing helper.
package hex_display_pkg;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g patterns (bit 0 = a, bit 6 = g), indexed by hex digit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width of a counter holding 0..div-1; never narrower than one bit.
  function automatic int unsigned blink_cnt_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble-to-seven-segment lookup with a forced-blank override.
module hex7seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the digit pattern.
  always_comb begin
    seg_o = blank_i ? SEG_BLANK : SEG_LUT[digit_i];
  end

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment controller: value register with hex/BCD increment,
// leading-zero blanking, per-digit blink and a registered HEX output.
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  input  logic                      inc,
  input  logic                      bcd_mode,
  input  logic                      blank_lz,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [4*NUM_DIGITS-1:0]   value,
  output logic                      wrap,
  output logic                      bcd_err,
  output logic [7*NUM_DIGITS-1:0]   HEX
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam int unsigned HW   = 7 * NUM_DIGITS;
  localparam int unsigned CntW = blink_cnt_width(BLINK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_DIV - 1);

  logic [W-1:0]          value_q, value_d;
  logic                  wrap_q, wrap_d;
  logic                  bcd_err_q, bcd_err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [HW-1:0]         hex_q, hex_d;

  logic [W-1:0]          hex_sum;
  logic                  hex_carry;
  logic [W-1:0]          bcd_sum;
  logic                  bcd_carry;
  logic                  load_has_gt9;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic                  cnt_last;

  // Binary increment with carry-out marking rollover from all-F.
  always_comb begin
    {hex_carry, hex_sum} = {1'b0, value_q} + (W + 1)'(1);
  end

  // Decimal ripple increment; digits above 9 behave as 9 and carry onward.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    carry   = 1'b1;
    digit   = 4'd0;
    bcd_sum = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = value_q[4*i +: 4];
      if (!carry) begin
        bcd_sum[4*i +: 4] = digit;
      end else if (digit >= 4'd9) begin
        bcd_sum[4*i +: 4] = 4'd0;
      end else begin
        bcd_sum[4*i +: 4] = digit + 4'd1;
        carry             = 1'b0;
      end
    end
    bcd_carry = carry;
  end

  // Flag any non-decimal nibble in the incoming load word.
  always_comb begin
    load_has_gt9 = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_data[4*i +: 4] > 4'd9) begin
        load_has_gt9 = 1'b1;
      end
    end
  end

  // Value register next state: load beats inc; wrap only from an inc rollover.
  always_comb begin
    value_d   = value_q;
    wrap_d    = 1'b0;
    bcd_err_d = bcd_err_q;
    if (load) begin
      value_d = load_data;
      if (bcd_mode && load_has_gt9) begin
        bcd_err_d = 1'b1;
      end
    end else if (inc) begin
      if (bcd_mode) begin
        value_d = bcd_sum;
        wrap_d  = bcd_carry;
      end else begin
        value_d = hex_sum;
        wrap_d  = hex_carry;
      end
    end
  end

  // Free-running blink divider; phase flips each time the counter wraps.
  always_comb begin
    cnt_last = (cnt_q == CntLast);
    cnt_d    = cnt_last ? '0 : cnt_q + CntW'(1);
    phase_d  = phase_q ^ cnt_last;
  end

  // Per-digit blanking: leading zeros (never digit 0) ORed with blink.
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    digit_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above     = zero_above & (value_q[4*i +: 4] == 4'd0);
      digit_blank[i] = (blank_lz && (i != 0) && zero_above) ||
                       (phase_q && blink_mask[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dec
    hex7seg_decode u_dec (
      .digit_i (value_q[4*g +: 4]),
      .blank_i (digit_blank[g]),
      .seg_o   (hex_d[7*g +: 7])
    );
  end

  // State registers; reset leaves the display fully blank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q   <= '0;
      wrap_q    <= 1'b0;
      bcd_err_q <= 1'b0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      hex_q     <= '1;
    end else begin
      value_q   <= value_d;
      wrap_q    <= wrap_d;
      bcd_err_q <= bcd_err_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      hex_q     <= hex_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    value   = value_q;
    wrap    = wrap_q;
    bcd_err = bcd_err_q;
    HEX     = hex_q;
  end

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank (4 digits, blink every 4 cycles).
module tb_hex_display_bank;

  localparam int ND = 4;
  localparam int BD = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [15:0] load_data;
  logic        inc;
  logic        bcd_mode;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [15:0] value;
  logic        wrap;
  logic        bcd_err;
  logic [27:0] HEX;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [15:0] m_val;
  logic        m_wrap;
  logic        m_err;
  logic [27:0] m_hex;
  int          m_edges;

  hex_display_bank #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_data  (load_data),
    .inc        (inc),
    .bcd_mode   (bcd_mode),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .value      (value),
    .wrap       (wrap),
    .bcd_err    (bcd_err),
    .HEX        (HEX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected display for a value under the given phase and mode inputs.
  function automatic logic [27:0] disp(input logic [15:0] v, input logic ph, input logic blz,
                                       input logic [3:0] msk);
    logic [27:0] r;
    logic        blank;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      blank = (blz && i > 0 && (v >> (4 * i)) == 16'd0) || (ph && msk[i]);
      r[7*i +: 7] = blank ? 7'h7F : SEG_TAB[v[4*i +: 4]];
    end
    return r;
  endfunction

  function automatic logic has_gt9(input logic [15:0] v);
    for (int i = 0; i < ND; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_val   = '0;
    m_wrap  = 1'b0;
    m_err   = 1'b0;
    m_hex   = '1;
    m_edges = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic ld, input logic [15:0] ldd, input logic in_,
                            input logic bcd, input logic blz, input logic [3:0] msk);
    int k;
    int v;
    m_hex  = disp(m_val, ((m_edges / BD) % 2) == 1, blz, msk);
    m_wrap = 1'b0;
    if (ld) begin
      m_val = ldd;
      if (bcd && has_gt9(ldd)) m_err = 1'b1;
    end else if (in_) begin
      if (!bcd) begin
        v      = int'(m_val) + 1;
        m_wrap = (v == 65536);
        m_val  = 16'(v % 65536);
      end else begin
        // Lowest digit below 9 absorbs the +1; everything under it becomes 0.
        k = -1;
        for (int i = 0; i < ND; i++) begin
          if (k < 0 && m_val[4*i +: 4] < 4'd9) k = i;
        end
        if (k < 0) begin
          m_val  = '0;
          m_wrap = 1'b1;
        end else begin
          v     = ((int'(m_val) >> (4 * k)) + 1) << (4 * k);
          m_val = 16'(v);
        end
      end
    end
    m_edges++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".value"}, 32'(value), 32'(m_val));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, ".bcd_err"}, 32'(bcd_err), 32'(m_err));
    chk({tag, ".hex"}, 32'(HEX), 32'(m_hex));
  endtask

  task automatic cycle(input string tag, input logic ld, input logic [15:0] ldd, input logic in_,
                       input logic bcd, input logic blz, input logic [3:0] msk);
    load       = ld;
    load_data  = ldd;
    inc        = in_;
    bcd_mode   = bcd;
    blank_lz   = blz;
    blink_mask = msk;
    @(posedge clk);
    model_edge(ld, ldd, in_, bcd, blz, msk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] rd;
    logic        rbcd;
    resetn     = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    inc        = 1'b0;
    bcd_mode   = 1'b0;
    blank_lz   = 1'b0;
    blink_mask = '0;
    model_reset();

    // Reset state.
    #12;
    chk("rst.hex", 32'(HEX), 32'h0FFFFFFF);
    chk("rst.value", 32'(value), 32'h0);
    chk("rst.wrap", 32'(wrap), 32'h0);
    chk("rst.bcd_err", 32'(bcd_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    cycle("idle0", 0, 16'h0, 0, 0, 0, 4'h0);
    cycle("idle1", 0, 16'h0, 0, 0, 0, 4'h0);
    chk("idle.hex", 32'(HEX), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

    // Hex mode load / display / rollover.
    cycle("ld12af", 1, 16'h12AF, 0, 0, 0, 4'h0);
    chk("ld12af.value", 32'(value), 32'h12AF);
    cycle("show12af", 0, 16'h0, 0, 0, 0, 4'h0);
    chk("show12af.hex", 32'(HEX), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));
    cycle("ldffff", 1, 16'hFFFF, 0, 0, 0, 4'h0);
    cycle("incffff", 0, 16'h0, 1, 0, 0, 4'h0);
    chk("incffff.wrap", 32'(wrap), 32'h1);
    cycle("wrapdrop", 0, 16'h0, 0, 0, 0, 4'h0);
    chk("wrapdrop.wrap", 32'(wrap), 32'h0);

    // BCD mode with leading-zero blanking.
    cycle("ld0999", 1, 16'h0999, 0, 1, 1, 4'h0);
    cycle("inc0999", 0, 16'h0, 1, 1, 1, 4'h0);
    chk("inc0999.value", 32'(value), 32'h1000);
    cycle("show1000", 0, 16'h0, 0, 1, 1, 4'h0);
    chk("show1000.d3", 32'(HEX[27:21]), 32'h79);
    cycle("ld0009", 1, 16'h0009, 0, 1, 1, 4'h0);
    cycle("inc0009", 0, 16'h0, 1, 1, 1, 4'h0);
    chk("inc0009.value", 32'(value), 32'h0010);
    cycle("show0010", 0, 16'h0, 0, 1, 1, 4'h0);
    chk("show0010.d32", 32'(HEX[27:14]), 32'({7'h7F, 7'h7F}));
    cycle("ld9999", 1, 16'h9999, 0, 1, 1, 4'h0);
    cycle("inc9999", 0, 16'h0, 1, 1, 1, 4'h0);
    chk("inc9999.wrap", 32'(wrap), 32'h1);
    cycle("show0000", 0, 16'h0, 0, 1, 1, 4'h0);
    chk("show0000.hex", 32'(HEX), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    cycle("ld00a0", 1, 16'h00A0, 0, 1, 1, 4'h0);
    chk("ld00a0.err", 32'(bcd_err), 32'h1);
    cycle("ld0001", 1, 16'h0001, 0, 1, 1, 4'h0);
    chk("ld0001.err", 32'(bcd_err), 32'h1);

    // Load beats inc, even from all-F.
    cycle("ldffff2", 1, 16'hFFFF, 0, 0, 0, 4'h0);
    cycle("prio", 1, 16'h0005, 1, 0, 0, 4'h0);
    chk("prio.value", 32'(value), 32'h0005);
    chk("prio.wrap", 32'(wrap), 32'h0);

    // Blink on digit 0 only.
    cycle("ld1234", 1, 16'h1234, 0, 0, 0, 4'h1);
    for (int i = 0; i < 12; i++) begin
      cycle("blink", 0, 16'h0, 0, 0, 0, 4'h1);
      chk("blink.d31", 32'(HEX[27:7]), 32'({7'h79, 7'h24, 7'h30}));
    end
    // Move into the blanked half of the blink period, then reset asynchronously.
    for (int i = 0; i < 16 && !(((m_edges / BD) % 2) == 1 && (m_edges % BD) == 2); i++) begin
      cycle("seek", 0, 16'h0, 0, 0, 0, 4'h1);
    end
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("midrst.hex", 32'(HEX), 32'h0FFFFFFF);
    chk("midrst.value", 32'(value), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle("postrst", 0, 16'h0, 0, 0, 0, 4'h1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rbcd = 1'($urandom_range(0, 1));
      rd   = 16'($urandom);
      if (rbcd && $urandom_range(0, 3) != 0) begin
        for (int d = 0; d < ND; d++) rd[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) rd = rbcd ? 16'h9999 : 16'hFFFF;
      cycle("rand", ($urandom_range(0, 3) == 0), rd, 1'($urandom_range(0, 1)), rbcd,
            1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Parametrised multi-digit seven-segment display controller for the board HEX outputs. It holds a NUM_DIGITS-nibble value register that can be loaded or incremented in hexadecimal or BCD, and drives one active-low 7-segment field per digit. Each digit has an optional blink, and leading-zero blanking is available. It replaces per-digit combinational decoders wired straight to switches, and sits between lab datapaths (counters, ALUs, FSMs) and the HEX pins.

## Interface
- NUM_DIGITS, 6: number of digits, legal range 1..8.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period, minimum 2.

- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- load  in  1  strobe that writes load_data into the value register.
- load_data  in  4*NUM_DIGITS  new value; nibble i maps to digit i, with digit 0 rightmost.
- inc  in  1  strobe that increments the value register by 1.
- bcd_mode  in  1  1 selects decimal digit arithmetic, 0 selects hex.
- blank_lz  in  1  1 blanks leading zeros.
- blink_mask  in  NUM_DIGITS  per-digit blink enable.
- value  out  4*NUM_DIGITS  current value register.
- wrap  out  1  one-cycle pulse when inc rolls the value over to 0.
- bcd_err  out  1  sticky flag: a load in BCD mode carried a nibble greater than 9.
- HEX  out  7*NUM_DIGITS  segments. Field i is bits [7i+6:7i]; bit 0 = a, bit 6 = g; active-low.

## Operation
- Reset values: value = 0, wrap = 0, bcd_err = 0, blink counter = 0, blink phase = 0, HEX = all ones (all blank).
- Priority per cycle: load > inc. A simultaneous inc is dropped, and wrap stays 0.
- load: value <= load_data, with no digit filtering.
  - In bcd_mode, if any nibble is greater than 9, bcd_err is set and stays set until reset.
  - The loaded value is still stored.
- inc, hex mode: value <= value + 1 modulo 16^N. Rollover from all-F to 0 asserts wrap for one cycle.
- inc, BCD mode: ripple decimal add.
  - A digit equal to 9 becomes 0 and carries into the next digit.
  - A digit greater than 9 is treated as 9, i.e. it becomes 0 and carries.
  - Rollover from all-9 to 0 asserts wrap.
- Segment encoding, hex digit -> 7-bit active-low value:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Leading-zero blanking, when blank_lz = 1:
  - Digit i > 0 is blanked (7F) if it and every higher digit are 0.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
- Blink:
  - The counter runs 0..BLINK_DIV-1 continuously. At the terminal count it wraps to 0 and toggles phase.
  - While phase = 1, digits with blink_mask[i] = 1 show 7F.
  - Blink blanking and leading-zero blanking are ORed together.
- Mode inputs (bcd_mode, blank_lz, blink_mask) are sampled every cycle. No latching.

## Timing
- value and wrap update on the clk edge that samples load or inc.
- HEX is registered. It reflects value, phase and mode inputs from the previous cycle, so load at edge k appears on HEX after edge k+1.
- bcd_err sets on the same edge as the offending load.
- Asynchronous resetn assertion mid-count or mid-blink immediately forces every reset value. The first edge after release counts as blink cycle 0.
- Back-to-back inc on consecutive cycles is legal: one increment per cycle.

## Structure
- Package hex_display_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry segment lookup constant.
  - Localparam helpers for the blink counter width, $clog2(BLINK_DIV).
- Sub-module hex7seg_decode: combinational nibble-to-segment lookup plus a blank input. Instantiated NUM_DIGITS times through a generate loop.
- Top level holds the value register, the increment and carry chain, the blink counter, the blanking logic and the HEX output register.

## Test plan
Bench parameters: NUM_DIGITS = 4, BLINK_DIV = 4.
- Reset: hold resetn low -> HEX = 0x0FFFFFFF, value = 0, wrap = 0. Release, then two edges with no strobes -> HEX digit fields = 40, 40, 40, 40.
- Hex mode: load 0x12AF with blank_lz = 0 -> value 0x12AF on the same edge; next edge HEX digits 3..0 = 79, 24, 08, 0E. Then load FFFF, then inc -> value 0000, wrap high for exactly one cycle.
- BCD mode: load 0x0999 with blank_lz = 1, then inc -> value 0x1000, digit 3 = 79. Load 0x0009, then inc -> 0x0010, digits 3..2 = 7F, 7F. Load 9999, then inc -> 0000, wrap = 1, HEX shows only digit 0 = 40. Load 0x00A0 -> bcd_err = 1, and it stays 1 after a further load of 0x0001.
- Priority: load = 1 and inc = 1 in the same cycle with load_data 0x0005 -> value 0x0005, wrap = 0.
- Blink: blink_mask = 4'b0001, value 0x1234 -> digit 0 alternates 19 / 7F every 4 cycles; digits 3..1 stay steady. Assert resetn mid-phase -> HEX immediately all 7F, phase = 0.
